// File: rtl/banner_pkg.sv
// Shared types and constants for the banner renderer: FSM states, character codes
// and the width helpers used for the address shifts.
package banner_pkg;

    localparam int unsigned CODE_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [CODE_W-1:0] CH_BLANK = 6'd0;
    localparam logic [CODE_W-1:0] CH_E     = 6'd5;
    localparam logic [CODE_W-1:0] CH_I     = 6'd9;
    localparam logic [CODE_W-1:0] CH_N     = 6'd14;
    localparam logic [CODE_W-1:0] CH_R     = 6'd18;
    localparam logic [CODE_W-1:0] CH_W     = 6'd23;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bit width needed to hold values 0..v-1, never less than one bit.
    function automatic int unsigned width(input int unsigned v);
        return (clog2(v) == 0) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/banner_font_rom.sv
// Combinational 8x8 bitmap font for the banner; gx=0 is the leftmost column.
// Codes without a glyph, and coordinates outside the 8x8 cell, read as unlit.
module banner_font_rom
    import banner_pkg::*;
#(
    parameter int unsigned GLYPH_W = 8,
    parameter int unsigned GLYPH_H = 8,
    localparam int unsigned GX_W = width(GLYPH_W),
    localparam int unsigned GY_W = width(GLYPH_H)
) (
    input  logic [CODE_W-1:0] code_i,
    input  logic [GY_W-1:0]   gy_i,
    input  logic [GX_W-1:0]   gx_i,
    output logic              bit_o
);

    logic [63:0] rows;
    logic [7:0]  row_bits;
    logic [2:0]  gy3;
    logic [2:0]  gx3;
    logic        in_cell;

    always_comb begin
        case (code_i)
            CH_BLANK: rows = 64'h0000_0000_0000_0000;
            CH_W:     rows = 64'hC3C3_C3DB_DBFF_6600;
            CH_I:     rows = 64'h7E18_1818_1818_7E00;
            CH_N:     rows = 64'hC3E3_F3DB_CFC7_C300;
            CH_E:     rows = 64'hFFC0_C0FE_C0C0_FF00;
            CH_R:     rows = 64'hFEC3_C3FE_D8CC_C600;
            default:  rows = 64'h0000_0000_0000_0000;
        endcase
    end

    always_comb begin
        gy3      = 3'(gy_i);
        gx3      = 3'(gx_i);
        in_cell  = (32'(gy_i) < 8) && (32'(gx_i) < 8);
        // Row 0 sits in the top byte of the packed glyph constant.
        row_bits = 8'(rows >> {3'd7 - gy3, 3'b000});
        bit_o    = in_cell && row_bits[3'd7 - gx3];
    end

endmodule

// File: rtl/banner_scroller.sv
// Text banner that scrolls up from START_ROW to STOP_ROW and renders a scaled bitmap font.
// Optional: define BANNER_BLINK_EN to blink the banner while it holds at STOP_ROW.
module banner_scroller
    import banner_pkg::*;
#(
    parameter int unsigned MSG_LEN   = 8,
    parameter int unsigned GLYPH_W   = 8,
    parameter int unsigned GLYPH_H   = 8,
    parameter int unsigned SCALE     = 4,
    parameter int unsigned START_COL = 195,
    parameter int unsigned START_ROW = 480,
    parameter int unsigned STOP_ROW  = 100,
    parameter int unsigned STEP      = 3,
    parameter int unsigned TICK_DIV  = 2000000,
    parameter logic [3:0]  COLOR     = 4'hF
`ifdef BANNER_BLINK_EN
    ,
    parameter int unsigned BLINK_TICKS = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [11:0]                 pixel_row,
    input  logic [11:0]                 pixel_column,
    input  logic                        start,
    input  logic [MSG_LEN*CODE_W-1:0]   msg_codes,
    output logic [3:0]                  banner_pix,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned SCALE_SH = clog2(SCALE);
    localparam int unsigned CHAR_SH  = clog2(GLYPH_W * SCALE);
    localparam int unsigned GX_W     = width(GLYPH_W);
    localparam int unsigned GY_W     = width(GLYPH_H);
    localparam int unsigned CHAR_W   = width(MSG_LEN);
    localparam int unsigned TICK_W   = width(TICK_DIV);
    localparam int unsigned BOX_W    = MSG_LEN * GLYPH_W * SCALE;
    localparam int unsigned BOX_H    = GLYPH_H * SCALE;

    state_t                      state_q, state_d;
    logic [11:0]                 row_q, row_d;
    logic [TICK_W-1:0]           tick_q, tick_d;
    logic [MSG_LEN*CODE_W-1:0]   msg_q, msg_d;
    logic [3:0]                  pix_q, pix_d;

    logic                        tick_wrap;
    logic [TICK_W-1:0]           tick_nxt;
    logic [12:0]                 row_sub;
    logic [11:0]                 row_step;

    logic [12:0]                 dx, dy;
    logic                        hit;
    logic [CHAR_W-1:0]           char_idx;
    logic [GX_W-1:0]             gx;
    logic [GY_W-1:0]             gy;
    logic [CODE_W-1:0]           code;
    logic                        font_bit;
    logic                        blank_phase;

    always_comb begin
        tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));
        tick_nxt  = tick_wrap ? '0 : tick_q + 1'b1;
        // 13-bit subtraction so a step past row 0 shows up as a set sign bit.
        row_sub   = {1'b0, row_q} - 13'(STEP);
        row_step  = (row_sub[12] || (row_sub <= 13'(STOP_ROW))) ? 12'(STOP_ROW) : row_sub[11:0];
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tick_d  = tick_q;
        msg_d   = msg_q;
        if (!start) begin
            state_d = IDLE;
            row_d   = 12'(START_ROW);
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SCROLL;
                    row_d   = 12'(START_ROW);
                    tick_d  = '0;
                    msg_d   = msg_codes;
                end
                SCROLL: begin
                    tick_d = tick_nxt;
                    if (tick_wrap) begin
                        row_d = row_step;
                        if (row_step == 12'(STOP_ROW)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    row_d = 12'(STOP_ROW);
`ifdef BANNER_BLINK_EN
                    tick_d = tick_nxt;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef BANNER_BLINK_EN
    localparam int unsigned BLINK_W = width(BLINK_TICKS);

    logic               phase_q, phase_d;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;

    // Phase and its tick counter sit at zero outside HOLD, so HOLD always starts lit.
    always_comb begin
        phase_d = 1'b0;
        bcnt_d  = '0;
        if (start && (state_q == HOLD)) begin
            phase_d = phase_q;
            bcnt_d  = bcnt_q;
            if (tick_wrap) begin
                if (bcnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                    bcnt_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign blank_phase = phase_q;
`else
    assign blank_phase = 1'b0;
`endif

    always_comb begin
        dx       = {1'b0, pixel_column} - 13'(START_COL);
        dy       = {1'b0, pixel_row} - {1'b0, row_q};
        hit      = !dx[12] && !dy[12] && (dx < 13'(BOX_W)) && (dy < 13'(BOX_H));
        char_idx = CHAR_W'(dx >> CHAR_SH);
        gx       = GX_W'(dx >> SCALE_SH);
        gy       = GY_W'(dy >> SCALE_SH);
        code     = '0;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            if (char_idx == CHAR_W'(i)) begin
                code = msg_q[i*CODE_W +: CODE_W];
            end
        end
    end

    banner_font_rom #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H)
    ) u_font (
        .code_i (code),
        .gy_i   (gy),
        .gx_i   (gx),
        .bit_o  (font_bit)
    );

    always_comb begin
        pix_d = (hit && font_bit && (state_q != IDLE) && !blank_phase) ? COLOR : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= 12'(START_ROW);
            tick_q  <= '0;
            msg_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tick_q  <= tick_d;
            msg_q   <= msg_d;
            pix_q   <= pix_d;
        end
    end

    assign banner_pix = pix_q;
    assign busy       = (state_q == SCROLL);
    assign done       = (state_q == HOLD);

endmodule

// File: tb/tb_banner_scroller.sv
// Directed bench for banner_scroller with TICK_DIV=4 (BLINK_TICKS=2 when BANNER_BLINK_EN is defined).
module tb_banner_scroller;
    import banner_pkg::*;

    localparam logic [3:0] COL = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic [47:0] msg_codes;
    logic [3:0]  banner_pix;
    logic        busy;
    logic        done;

    int n_cmp     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int hold_base = 0;
    bit in_hold   = 1'b0;

    localparam logic [47:0] MSG_WIN = {CH_BLANK, CH_BLANK, CH_R, CH_E, CH_N, CH_N, CH_I, CH_W};
    localparam logic [47:0] MSG_E   = {{7{CH_BLANK}}, CH_E};

    always #5 clk = ~clk;

    banner_scroller #(
        .MSG_LEN   (8),
        .GLYPH_W   (8),
        .GLYPH_H   (8),
        .SCALE     (4),
        .START_COL (195),
        .START_ROW (480),
        .STOP_ROW  (100),
        .STEP      (3),
        .TICK_DIV  (4),
        .COLOR     (4'hF)
`ifdef BANNER_BLINK_EN
        ,
        .BLINK_TICKS (2)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .start        (start),
        .msg_codes    (msg_codes),
        .banner_pix   (banner_pix),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Output after edge n of HOLD reflects the phase held after edge n-1; phase flips every 8 clks.
    function automatic bit blanked();
`ifdef BANNER_BLINK_EN
        return in_hold && ((((cyc - hold_base - 1) / 8) % 2) == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic probe(input string tag, input int r, input int c, input logic [3:0] expv);
        pixel_row    = 12'(r);
        pixel_column = 12'(c);
        tick();
        chk(tag, banner_pix, blanked() ? 4'h0 : expv);
    endtask

    initial begin
        int exp_row;
        rst          = 1'b1;
        start        = 1'b1;
        msg_codes    = MSG_WIN;
        pixel_row    = '0;
        pixel_column = '0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_pix", banner_pix, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_row", dut.row_q, 480);
        end

        rst = 1'b0;
        tick();
        chk("start_busy", busy, 1);
        chk("start_row", dut.row_q, 480);

        for (int k = 1; k <= 127; k++) begin
            repeat (4) tick();
            exp_row = 480 - 3 * k;
            if (exp_row < 100) exp_row = 100;
            chk("scroll_row", dut.row_q, exp_row);
            chk("scroll_done", done, (k == 127) ? 1 : 0);
            chk("scroll_busy", busy, (k == 127) ? 0 : 1);
        end
        hold_base = cyc;
        in_hold   = 1'b1;

        pixel_row    = 12'd100;
        pixel_column = 12'd195;
        #1;
        chk("latency_pre", banner_pix, 0);
        tick();
        chk("latency_post", banner_pix, blanked() ? 4'h0 : COL);
        for (int i = 0; i < 23; i++) begin
            tick();
            chk("hold_pix", banner_pix, blanked() ? 4'h0 : COL);
        end

        probe("box_right", 100, 451, 4'h0);
        probe("row_above", 99, 195, 4'h0);
        probe("col_left", 100, 194, 4'h0);
        probe("box_bottom", 132, 195, 4'h0);
        probe("w_row5", 123, 195, COL);
        probe("w_row6", 127, 195, 4'h0);
        probe("i_on", 100, 231, COL);
        probe("i_off", 100, 227, 4'h0);
        probe("n_on", 112, 271, COL);
        probe("n_off", 112, 267, 4'h0);
        probe("r_left", 104, 355, COL);
        probe("r_right", 104, 386, COL);
        probe("blank6", 100, 387, 4'h0);
        chk("hold_row", dut.row_q, 100);
        chk("hold_done", done, 1);

        in_hold      = 1'b0;
        pixel_row    = '0;
        pixel_column = '0;
        start        = 1'b0;
        tick();
        chk("drop_busy", busy, 0);
        chk("drop_done", done, 0);
        chk("drop_row", dut.row_q, 480);

        start     = 1'b1;
        msg_codes = MSG_WIN;
        tick();
        chk("rescroll_busy", busy, 1);
        for (int k = 1; k <= 60; k++) begin
            repeat (4) tick();
            chk("rescroll_row", dut.row_q, 480 - 3 * k);
        end

        pixel_row    = 12'd300;
        pixel_column = 12'd195;
        start        = 1'b0;
        tick();
        chk("mid_drop_busy", busy, 0);
        chk("mid_drop_row", dut.row_q, 480);
        pixel_row = 12'd480;
        tick();
        chk("idle_pix", banner_pix, 0);

        msg_codes    = MSG_E;
        start        = 1'b1;
        pixel_row    = 12'd492;
        pixel_column = 12'd203;
        tick();
        chk("restart_busy", busy, 1);
        tick();
        chk("new_code", banner_pix, COL);
        msg_codes = MSG_WIN;
        tick();
        chk("latched_code", banner_pix, COL);
        tick();
        chk("tick_clear_hold", dut.row_q, 480);
        tick();
        chk("tick_clear_step", dut.row_q, 477);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
